// File: rtl/lut3_sweep_checker_pkg.sv
// Shared types and sizes for the 3-input exhaustive sweep checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lut3_sweep_pkg;

  localparam int VEC_W = 3;
  localparam int N_VEC = 8;
  localparam int ERR_W = 4;
  localparam int TMR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/lut3_sweep_checker_if.sv
// Bundle between the sweep checker and its lab environment (requester + DUT under test).
// Latency: n/a (wires only).
// Backpressure: none; start is a level request sampled when the checker is not running.
interface lut3_sweep_checker_if;
  import lut3_sweep_pkg::*;

  logic               start;
  logic [N_VEC-1:0]   expected_lut;
  logic               dut_out;
  logic [VEC_W-1:0]   vec;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ERR_W-1:0]   err_count;
  logic [VEC_W-1:0]   first_fail_idx;
  logic               first_fail_valid;

  // Checker side: consumes the request and the DUT response, drives vectors and results.
  modport master (
    input  start, expected_lut, dut_out,
    output vec, busy, done, pass, err_count, first_fail_idx, first_fail_valid
  );

  // Environment side: requester plus the DUT wired onto vec/dut_out.
  modport slave (
    output start, expected_lut, dut_out,
    input  vec, busy, done, pass, err_count, first_fail_idx, first_fail_valid
  );

endinterface

// File: rtl/lut3_sweep_checker_settle_timer.sv
// Loadable down-counter that paces how long each vector is held before sampling.
// Latency: zero is registered-count based; reflects a load one cycle after the loading edge.
// Backpressure: none; counts only while en is high and stops at zero.
module settle_timer
  import lut3_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] cnt;

  // Load has priority over counting; the count parks at zero until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lut3_sweep_checker.sv
// Steps a 3-input DUT through all 8 vectors and checks each response against a captured truth table.
// Latency: 8*(SETTLE_CYCLES+1) cycles from start acceptance to the one-cycle done pulse.
// Backpressure: start is ignored while a sweep is running; results hold until the next accepted start.
module lut3_sweep_checker
  import lut3_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  lut3_sweep_checker_if.master io
);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES);

  sweep_state_t     state;
  logic [N_VEC-1:0] lut_q;
  logic [VEC_W-1:0] vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [VEC_W-1:0] ffi_q;
  logic             ffv_q;

  logic             accept;
  logic             tmr_zero;
  logic             cmp_now;
  logic             last_vec;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  assign accept   = io.start && (state != RUN);
  assign cmp_now  = (state == RUN) && tmr_zero;
  assign last_vec = (vec_q == VEC_W'(N_VEC - 1));
  // 4-state inequality so an X/Z response from the DUT is flagged rather than silently matching.
  assign mismatch = (io.dut_out !== lut_q[vec_q]);
  assign err_next = err_q + ERR_W'(mismatch);

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || (cmp_now && !last_vec)),
    .en       (state == RUN),
    .load_val (SETTLE_LD),
    .zero     (tmr_zero)
  );

  // Sweep sequencer with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lut_q  <= '0;
      vec_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      ffi_q  <= '0;
      ffv_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          vec_q  <= '0;
          if (io.start) begin
            state  <= RUN;
            lut_q  <= io.expected_lut;
            busy_q <= 1'b1;
            pass_q <= 1'b0;
            err_q  <= '0;
            ffi_q  <= '0;
            ffv_q  <= 1'b0;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          if (cmp_now) begin
            err_q <= err_next;
            if (mismatch && !ffv_q) begin
              ffi_q <= vec_q;
              ffv_q <= 1'b1;
            end
            if (last_vec) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              vec_q  <= '0;
              pass_q <= (err_next == '0);
            end else begin
              vec_q  <= vec_q + VEC_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign io.vec              = vec_q;
  assign io.busy             = busy_q;
  assign io.done             = done_q;
  assign io.pass             = pass_q;
  assign io.err_count        = err_q;
  assign io.first_fail_idx   = ffi_q;
  assign io.first_fail_valid = ffv_q;

endmodule

// File: tb/tb_lut3_sweep_checker.sv
// Self-checking bench: two checker instances (settle 2 and settle 0) driven against truth-table DUT models.
// Latency: checks every cycle of each sweep against the expected cadence.
// Backpressure: exercises ignored mid-sweep start, mid-sweep reset and back-to-back restarts.
module tb_lut3_sweep_checker;
  import lut3_sweep_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;        // 0: SETTLE_CYCLES=2 instance, 1: SETTLE_CYCLES=0 instance
  logic [7:0] lut_drv;
  logic [7:0] tt_drv;     // truth table of the modelled lab DUT

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lut3_sweep_checker_if if2 ();
  lut3_sweep_checker_if if0 ();

  assign if2.start        = sel ? 1'b0 : start;
  assign if0.start        = sel ? start : 1'b0;
  assign if2.expected_lut = lut_drv;
  assign if0.expected_lut = lut_drv;
  assign if2.dut_out      = tt_drv[if2.vec];
  assign if0.dut_out      = tt_drv[if0.vec];

  lut3_sweep_checker #(.SETTLE_CYCLES(2)) u_chk_s2 (.clk(clk), .rst(rst), .io(if2.master));
  lut3_sweep_checker #(.SETTLE_CYCLES(0)) u_chk_s0 (.clk(clk), .rst(rst), .io(if0.master));

  logic [2:0] o_vec;
  logic       o_busy, o_done, o_pass, o_ffv;
  logic [3:0] o_err;
  logic [2:0] o_ffi;

  always_comb begin
    o_vec  = sel ? if0.vec              : if2.vec;
    o_busy = sel ? if0.busy             : if2.busy;
    o_done = sel ? if0.done             : if2.done;
    o_pass = sel ? if0.pass             : if2.pass;
    o_err  = sel ? if0.err_count        : if2.err_count;
    o_ffi  = sel ? if0.first_fail_idx   : if2.first_fail_idx;
    o_ffv  = sel ? if0.first_fail_valid : if2.first_fail_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
    end
  endtask

  // Reference result: mismatching vectors are the set bits of lut^tt.
  function automatic void ref_result(input logic [7:0] lut, input logic [7:0] tt,
                                     output int errs, output int ffi, output bit ffv);
    logic [7:0] diff;
    diff = lut ^ tt;
    errs = $countones(diff);
    ffv  = (diff != 8'h00);
    ffi  = 0;
    for (int k = 7; k >= 0; k--) if (diff[k]) ffi = k;
  endfunction

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_vec"},  o_vec,  0);
    chk({pfx, "_busy"}, o_busy, 0);
    chk({pfx, "_done"}, o_done, 0);
    chk({pfx, "_pass"}, o_pass, 0);
    chk({pfx, "_err"},  o_err,  0);
    chk({pfx, "_ffi"},  o_ffi,  0);
    chk({pfx, "_ffv"},  o_ffv,  0);
  endtask

  // Caller is at a negedge with start already raised; the next posedge is E0.
  task automatic run_body(input int s, input logic [7:0] lut, input logic [7:0] tt,
                          input int start_at, input int rst_at,
                          input bit restart, input logic [7:0] nlut, input logic [7:0] ntt);
    int per;
    int errs, ffi;
    bit ffv;
    per = s + 1;
    ref_result(lut, tt, errs, ffi, ffv);
    @(negedge clk);
    start = 1'b0;
    chk("clr_err",  o_err,  0);
    chk("clr_ffv",  o_ffv,  0);
    chk("clr_pass", o_pass, 0);
    for (int c = 0; c < 8 * per; c++) begin
      if (c > 0) @(negedge clk);
      chk("busy",    o_busy, 1);
      chk("vec",     o_vec,  c / per);
      chk("done_lo", o_done, 0);
      start = (c == start_at);
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk_reset_vals("midrst");
        for (int j = 0; j < 8 * per + 2; j++) begin
          @(negedge clk);
          chk("rst_nodone", o_done, 0);
          chk("rst_nobusy", o_busy, 0);
        end
        return;
      end
    end
    @(negedge clk);
    chk("done_hi",  o_done, 1);
    chk("end_busy", o_busy, 0);
    chk("end_vec",  o_vec,  0);
    chk("err",      o_err,  errs);
    chk("ffi",      o_ffi,  ffi);
    chk("ffv",      o_ffv,  ffv);
    chk("pass",     o_pass, (errs == 0));
    start = restart;
    if (restart) begin
      lut_drv = nlut;
      tt_drv  = ntt;
    end
  endtask

  task automatic begin_sweep(input logic s_sel, input logic [7:0] lut, input logic [7:0] tt);
    @(negedge clk);
    sel     = s_sel;
    lut_drv = lut;
    tt_drv  = tt;
    start   = 1'b1;
  endtask

  task automatic idle_after(input bit exp_pass);
    @(negedge clk);
    chk("idle_done", o_done, 0);
    chk("idle_busy", o_busy, 0);
    chk("hold_pass", o_pass, exp_pass);
  endtask

  initial begin
    bit         chained;
    bit         rs;
    logic       s_sel;
    logic [7:0] l, t, nl, nt;

    rst = 1'b1; start = 1'b1; sel = 1'b0; lut_drv = 8'hFE; tt_drv = 8'hFE;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_s2");
    sel = 1'b1; #1;
    chk_reset_vals("rst_s0");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("nosweep_s0", o_busy, 0);
    sel = 1'b0; #1;
    chk("nosweep_s2", o_busy, 0);

    // Correct OR-3 DUT
    begin_sweep(1'b0, 8'hFE, 8'hFE);
    run_body(2, 8'hFE, 8'hFE, -1, -1, 1'b0, 8'h00, 8'h00);
    idle_after(1'b1);
    // Stuck-at-0 DUT
    begin_sweep(1'b0, 8'hFE, 8'h00);
    run_body(2, 8'hFE, 8'h00, -1, -1, 1'b0, 8'h00, 8'h00);
    idle_after(1'b0);
    // OR-3 DUT against the AND-3 table
    begin_sweep(1'b0, 8'h80, 8'hFE);
    run_body(2, 8'h80, 8'hFE, -1, -1, 1'b0, 8'h00, 8'h00);
    idle_after(1'b0);
    // start while vec=3 is ignored
    begin_sweep(1'b0, 8'hFE, 8'hFE);
    run_body(2, 8'hFE, 8'hFE, 10, -1, 1'b0, 8'h00, 8'h00);
    idle_after(1'b1);
    // rst while vec=4, then a full sweep
    begin_sweep(1'b0, 8'hFE, 8'h00);
    run_body(2, 8'hFE, 8'h00, -1, 12, 1'b0, 8'h00, 8'h00);
    begin_sweep(1'b0, 8'hFE, 8'hFE);
    run_body(2, 8'hFE, 8'hFE, -1, -1, 1'b0, 8'h00, 8'h00);
    idle_after(1'b1);
    // Back-to-back with no settle: failing sweep restarts straight into a passing one
    begin_sweep(1'b1, 8'hFE, 8'h00);
    run_body(0, 8'hFE, 8'h00, -1, -1, 1'b1, 8'hFE, 8'hFE);
    run_body(0, 8'hFE, 8'hFE, -1, -1, 1'b0, 8'h00, 8'h00);
    idle_after(1'b1);

    // Randomized sweeps, sometimes chained through the DONE cycle
    chained = 1'b0;
    l = 8'($urandom);
    t = 8'($urandom);
    s_sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!chained) begin
        s_sel = 1'($urandom_range(0, 1));
        begin_sweep(s_sel, l, t);
      end
      rs = (i < 9) && ($urandom_range(0, 1) == 1);
      nl = 8'($urandom);
      nt = ($urandom_range(0, 3) == 0) ? nl : 8'($urandom);
      run_body(s_sel ? 0 : 2, l, t, -1, -1, rs, nl, nt);
      if (!rs) idle_after($countones(l ^ t) == 0);
      chained = rs;
      l = nl;
      t = nt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lut3_sweep_checker.md
# lut3_sweep_checker

Exhaustive stimulus generator and response checker for 3-input combinational lab blocks such as the 3-input OR gate. On `start`, it steps the DUT inputs A2..A0 through all 8 combinations. For each vector it waits a programmable settle time, then compares the DUT output against an 8-bit expected truth table. It reports an error count, the first failing vector and a pass flag. It sits directly upstream of the DUT, driving it, and directly downstream of it, consuming its output, so the lab's hand-written stimulus sequences can be replaced by a self-checking synthesizable stage.

## Interface
- `SETTLE_CYCLES`, default 2: extra cycles each vector is held before sampling; legal range 0..15.
- `clk` in 1: single clock; everything is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: sweep request; accepted only in IDLE or DONE.
- `expected_lut` in 8: bit k is the expected DUT output for vector k = {A2,A1,A0}; captured on start acceptance.
- `dut_out` in 1: DUT output.
- `vec` out 3: DUT inputs {A2,A1,A0}.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at sweep end.
- `pass` out 1: last completed sweep had zero mismatches.
- `err_count` out 4: mismatch count of the current or last sweep, 0..8.
- `first_fail_idx` out 3: first mismatching vector index.
- `first_fail_valid` out 1: `first_fail_idx` is meaningful.

## Operation
- **States:**
  - IDLE → RUN on `start`.
  - RUN → DONE after the compare of vector 7.
  - DONE → IDLE unconditionally, or DONE → RUN if `start` is high.
  - `rst` → IDLE from any state.
- **Start acceptance:**
  - Latch `expected_lut`.
  - Clear `err_count`, `pass`, `first_fail_valid` and `first_fail_idx` (to 0).
  - Set `vec`=0 and load the settle timer with `SETTLE_CYCLES`.
- **RUN, each edge:**
  - If timer>0, decrement it.
  - Otherwise, compare `dut_out` with `lut_q[vec]`.
  - On a mismatch:
    - `err_count`++.
    - If `first_fail_valid`=0, set `first_fail_idx`=`vec` and `first_fail_valid`=1.
  - Then, if `vec`==7, go to DONE; otherwise `vec`++ and reload the timer.
- **DONE:**
  - `done`=1, `busy`=0, `vec`=0.
  - `pass`=1 iff the final `err_count`==0; it is written on the RUN→DONE edge.
- **Result hold:** results hold until the next start acceptance or `rst`.
- **Ignored inputs:**
  - `start` during RUN is ignored.
  - `expected_lut` changes after acceptance have no effect.
- **`err_count` width:** 4 bits; the maximum is 8, so it never wraps.
- **Unknown values:** an X or Z on `dut_out` counts as a mismatch in simulation, because the compare is 4-state inequality.

## Timing
- **Reset values:** `vec`=000, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_idx`=000, `first_fail_valid`=0.
- **Reset mid-sweep:** all outputs return to their reset values at the next edge, and no `done` pulse is produced.
- **Sweep cadence:** let E0 be the edge that accepts `start`.
  - From E0, `busy`=1 and `vec`=0.
  - Vector k is driven for exactly `SETTLE_CYCLES`+1 cycles.
  - Vector k is compared at edge E0+(k+1)·(`SETTLE_CYCLES`+1).
- **End of sweep:**
  - `done` is high for one cycle after edge E0+8·(`SETTLE_CYCLES`+1).
  - `busy` is high for 8·(`SETTLE_CYCLES`+1) cycles.
  - `err_count` and `first_fail_*` update in the cycle after the comparing edge.
- **`start` during DONE:** the next sweep begins with no IDLE gap, and `done` deasserts at that edge.
- **`rst` with `start` on the same edge:** `rst` wins.

## Structure
- **Package `lut3_sweep_pkg`:**
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t`.
  - Constants `VEC_W`=3, `N_VEC`=8, `ERR_W`=4, `TMR_W`=4.
- **Sub-module `settle_timer`:** loadable down-counter, `TMR_W` bits, with a `load` input and a `zero` output. It is instantiated once.

## Test plan
- **Reset:** hold `rst` for 2 cycles → all outputs at reset values; `start` pulses during `rst` cause no sweep.
- **Correct OR-3 DUT, `SETTLE_CYCLES`=2, `expected_lut`=8'hFE:**
  - `vec` steps 0..7, 3 cycles each.
  - `done` follows edge E0+24.
  - Final `pass`=1, `err_count`=0, `first_fail_valid`=0.
- **Stuck-at-0 DUT, `expected_lut`=8'hFE:** `err_count`=7, `first_fail_idx`=1, `first_fail_valid`=1, `pass`=0.
- **OR-3 DUT checked against the AND-3 table, `expected_lut`=8'h80:** mismatches at vectors 1..6, so `err_count`=6 and `first_fail_idx`=1; vectors 0 and 7 match.
- **Mid-sweep events:**
  - `start` while `vec`=3 is ignored; the sweep length is unchanged.
  - `rst` while `vec`=4 gives reset values at the next edge and no `done`.
  - A later `start` completes a full 8-vector sweep.
- **Back-to-back sweeps with `SETTLE_CYCLES`=0:**
  - `done` follows edge E0+8.
  - `start` asserted in the DONE cycle restarts with `vec`=0 the next cycle.
  - `err_count` is cleared before the second sweep accumulates.
